// File: rtl/ysyx_24100006_csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings,
// mstatus field layout and fixed identification values.
package ysyx_24100006_csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int          MSTATUS_MIE    = 3;
    localparam int          MSTATUS_MPIE   = 7;
    localparam int          MSTATUS_MPP_LO = 11;
    localparam int          MSTATUS_MPP_HI = 12;
    localparam logic [1:0]  MSTATUS_MPP    = 2'b11;

    localparam logic [31:0] MARCHID_VAL    = 32'h0018_0006;
    localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] r;
        r = '0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP;
        r[MSTATUS_MIE]  = mie;
        r[MSTATUS_MPIE] = mpie;
        return r;
    endfunction

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                              input logic [31:0] src);
        case (op)
            CSR_OP_RW: return src;
            CSR_OP_RS: return old_val | src;
            CSR_OP_RC: return old_val & ~src;
            default:   return old_val;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100006_csr_counter.sv
// Free-running wrap-around counter with 32-bit low/high write ports; a write
// replaces the addressed half and the increment is held off via inc_suppress.
module ysyx_24100006_csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    input  logic                 inc_suppress,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!inc_suppress) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            if (wr_lo) cnt_d = {cnt_q[CNT_WIDTH-1:32], wdata};
            // High half is narrower than 32 bits when CNT_WIDTH < 64.
            if (wr_hi) cnt_d = CNT_WIDTH'({wdata, cnt_q[31:0]});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_24100006_csr_unit.sv
// Machine-mode CSR unit: CSR read-modify-write, trap entry, mret and mcycle.
// Priority within one cycle is trap > mret > CSR write; reads are always live.
module ysyx_24100006_csr_unit
    import ysyx_24100006_csr_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int HAS_MSCRATCH = 1,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            csr_op,
    input  logic [ADDR_WIDTH-1:0] csr_addr,
    input  logic [DATA_WIDTH-1:0] csr_src,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_illegal,
    input  logic                  trap_valid,
    input  logic [DATA_WIDTH-1:0] trap_cause,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic                  mret_valid,
    output logic [DATA_WIDTH-1:0] mtvec,
    output logic [DATA_WIDTH-1:0] mepc,
    output logic                  mie_global
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mscratch_q, mscratch_d;

    logic [CNT_WIDTH-1:0] mcycle;
    logic [63:0]          mcycle64;
    logic [11:0]          addr;
    csr_op_e              op;
    logic [31:0]          old_val, new_val;
    logic                 implemented, read_only;
    logic                 is_write, illegal, do_write;
    logic                 cyc_wr_lo, cyc_wr_hi;

    assign addr     = 12'(csr_addr);
    assign op       = csr_op_e'(csr_op);
    assign mcycle64 = 64'(mcycle);

    always_comb begin
        implemented = 1'b1;
        read_only   = 1'b0;
        old_val     = '0;
        case (addr)
            CSR_MSTATUS:  old_val = mstatus_pack(mie_q, mpie_q);
            CSR_MTVEC:    old_val = mtvec_q;
            CSR_MSCRATCH: begin
                if (HAS_MSCRATCH != 0) old_val = mscratch_q;
                else                   implemented = 1'b0;
            end
            CSR_MEPC:     old_val = mepc_q;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MCYCLE:   old_val = mcycle64[31:0];
            CSR_MCYCLEH:  old_val = mcycle64[63:32];
            CSR_CYCLE: begin
                old_val   = mcycle64[31:0];
                read_only = 1'b1;
            end
            CSR_CYCLEH: begin
                old_val   = mcycle64[63:32];
                read_only = 1'b1;
            end
            CSR_MVENDORID: read_only = 1'b1;
            CSR_MARCHID: begin
                old_val   = MARCHID_VAL;
                read_only = 1'b1;
            end
            default: implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they never fault on read-only CSRs.
    assign is_write = (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && (csr_src != '0));
    assign illegal  = (op != CSR_OP_NONE) && (!implemented || (read_only && is_write));
    assign do_write = is_write && !illegal && !trap_valid && !mret_valid;
    assign new_val  = csr_apply(op, old_val, csr_src);

    assign cyc_wr_lo = do_write && (addr == CSR_MCYCLE);
    assign cyc_wr_hi = do_write && (addr == CSR_MCYCLEH);

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & ALIGN4_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (do_write) begin
            case (addr)
                CSR_MSTATUS: begin
                    mie_d  = new_val[MSTATUS_MIE];
                    mpie_d = new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = new_val & ALIGN4_MASK;
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val & ALIGN4_MASK;
                CSR_MCAUSE:   mcause_d   = new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
        end
    end

    ysyx_24100006_csr_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_mcycle (
        .clk         (clk),
        .reset       (reset),
        .wr_lo       (cyc_wr_lo),
        .wr_hi       (cyc_wr_hi),
        .wdata       (new_val),
        .inc_suppress(cyc_wr_lo | cyc_wr_hi),
        .cnt         (mcycle)
    );

    assign csr_rdata   = illegal ? '0 : old_val;
    assign csr_illegal = illegal;
    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign mie_global  = mie_q;

endmodule

// File: tb/tb_ysyx_24100006_csr_unit.sv
// Bench for the CSR unit: directed vector table, mid-run reset, then random
// traffic compared against a behavioural model of the CSR file.
module tb_ysyx_24100006_csr_unit;

    localparam logic [1:0] NO = 2'd0, RW = 2'd1, RS = 2'd2, RC = 2'd3;

    logic        clk, reset;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_src, csr_rdata, trap_cause, trap_pc, mtvec, mepc;
    logic        csr_illegal, trap_valid, mret_valid, mie_global;

    int checks = 0;
    int errors = 0;

    ysyx_24100006_csr_unit dut (
        .clk        (clk),
        .reset      (reset),
        .csr_op     (csr_op),
        .csr_addr   (csr_addr),
        .csr_src    (csr_src),
        .csr_rdata  (csr_rdata),
        .csr_illegal(csr_illegal),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .trap_pc    (trap_pc),
        .mret_valid (mret_valid),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mie_global (mie_global)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        bit          tv;
        logic [31:0] cause;
        logic [31:0] pc;
        bit          mr;
        logic [31:0] rd;
        bit          ill;
        logic [31:0] ep;
        bit          mie;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                               input bit tv, input logic [31:0] c, input logic [31:0] p,
                               input bit mr, input logic [31:0] rd, input bit ill,
                               input logic [31:0] ep, input bit mie);
        vec_t r;
        r.op = op; r.addr = a; r.src = s; r.tv = tv; r.cause = c; r.pc = p; r.mr = mr;
        r.rd = rd; r.ill = ill; r.ep = ep; r.mie = mie;
        return r;
    endfunction

    // Reference model of the architectural CSR state.
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscr;
    logic [63:0] m_cyc;

    function automatic void m_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mscr = 0; m_cyc = 0;
    endfunction

    function automatic void m_lookup(input logic [11:0] a, output bit impl, output bit ro,
                                     output logic [31:0] val);
        impl = 1; ro = 0; val = 0;
        case (a)
            12'h300: val = 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
            12'h305: val = m_mtvec;
            12'h340: val = m_mscr;
            12'h341: val = m_mepc;
            12'h342: val = m_mcause;
            12'hB00: val = m_cyc[31:0];
            12'hB80: val = m_cyc[63:32];
            12'hC00: begin val = m_cyc[31:0];  ro = 1; end
            12'hC80: begin val = m_cyc[63:32]; ro = 1; end
            12'hF11: ro = 1;
            12'hF12: begin val = 32'h0018_0006; ro = 1; end
            default: impl = 0;
        endcase
    endfunction

    function automatic void m_expect(output logic [31:0] rd, output bit ill, output bit wr,
                                     output logic [31:0] nv);
        bit impl, ro;
        logic [31:0] old;
        m_lookup(csr_addr, impl, ro, old);
        wr  = (csr_op == RW) || (csr_op != NO && csr_src != 0);
        ill = (csr_op != NO) && (!impl || (ro && wr));
        rd  = ill ? 32'h0 : old;
        nv  = (csr_op == RW) ? csr_src : (csr_op == RS) ? (old | csr_src) : (old & ~csr_src);
    endfunction

    function automatic void m_step();
        logic [31:0] rd, nv;
        bit ill, wr, bump;
        m_expect(rd, ill, wr, nv);
        bump = 1;
        if (trap_valid) begin
            m_mepc = {trap_pc[31:2], 2'b00};
            m_mcause = trap_cause;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (mret_valid) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (wr && !ill) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = {nv[31:2], 2'b00};
                12'h340: m_mscr = nv;
                12'h341: m_mepc = {nv[31:2], 2'b00};
                12'h342: m_mcause = nv;
                12'hB00: begin m_cyc[31:0] = nv; bump = 0; end
                12'hB80: begin m_cyc[63:32] = nv; bump = 0; end
                default: ;
            endcase
        end
        if (bump) m_cyc = m_cyc + 64'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] s,
                         input bit tv, input logic [31:0] c, input logic [31:0] p, input bit mr);
        csr_op = op; csr_addr = a; csr_src = s;
        trap_valid = tv; trap_cause = c; trap_pc = p; mret_valid = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    initial begin
        logic [11:0] addrs [12];
        logic [31:0] e_rd, e_nv;
        bit e_ill, e_wr;

        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                  12'hB80, 12'hC00, 12'hC80, 12'hF11, 12'hF12, 12'h7C0};

        //         op  addr     src           tv cause         pc            mr rdata         ill mepc          mie
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000_1800, 0, 32'h0,        0));
        vq.push_back(v(NO, 12'h305, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0));
        vq.push_back(v(NO, 12'h000, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0));
        vq.push_back(v(NO, 12'h342, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0));
        vq.push_back(v(NO, 12'h341, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0));
        vq.push_back(v(NO, 12'hB00, 32'h0,        0, 32'h0,        32'h0,        0, 32'd5,        0, 32'h0,        0));
        vq.push_back(v(RW, 12'h340, 32'hDEADBEEF, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0));
        vq.push_back(v(RS, 12'h340, 32'h10,       0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 0, 32'h0,        0));
        vq.push_back(v(RC, 12'h340, 32'hFFFF0000, 0, 32'h0,        32'h0,        0, 32'hDEADBEFF, 0, 32'h0,        0));
        vq.push_back(v(NO, 12'h340, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000BEFF, 0, 32'h0,        0));
        vq.push_back(v(RS, 12'h300, 32'h8,        0, 32'h0,        32'h0,        0, 32'h1800,     0, 32'h0,        0));
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1808,     0, 32'h0,        1));
        vq.push_back(v(RW, 12'h305, 32'h80000003, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        1));
        vq.push_back(v(NO, 12'h305, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000000, 0, 32'h0,        1));
        vq.push_back(v(NO, 12'h300, 32'h0,        1, 32'h80000007, 32'h80000102, 0, 32'h1808,     0, 32'h0,        1));
        vq.push_back(v(NO, 12'h341, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000100, 0, 32'h80000100, 0));
        vq.push_back(v(NO, 12'h342, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000007, 0, 32'h80000100, 0));
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        1, 32'h1880,     0, 32'h80000100, 0));
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1888,     0, 32'h80000100, 1));
        vq.push_back(v(RW, 12'h341, 32'h1234,     1, 32'h0000000B, 32'h00002008, 1, 32'h80000100, 0, 32'h80000100, 1));
        vq.push_back(v(NO, 12'h341, 32'h0,        0, 32'h0,        32'h0,        0, 32'h2008,     0, 32'h2008,     0));
        vq.push_back(v(NO, 12'h340, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000BEFF, 0, 32'h2008,     0));
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1880,     0, 32'h2008,     0));
        vq.push_back(v(RW, 12'hB00, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        0, 32'd23,       0, 32'h2008,     0));
        vq.push_back(v(RW, 12'hB80, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h2008,     0));
        vq.push_back(v(NO, 12'hB00, 32'h0,        0, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 0, 32'h2008,     0));
        vq.push_back(v(NO, 12'hB00, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h2008,     0));
        vq.push_back(v(NO, 12'hB80, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1,        0, 32'h2008,     0));
        vq.push_back(v(NO, 12'hC80, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1,        0, 32'h2008,     0));
        vq.push_back(v(NO, 12'hC00, 32'h0,        0, 32'h0,        32'h0,        0, 32'h3,        0, 32'h2008,     0));
        vq.push_back(v(RW, 12'hC00, 32'h100,      0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h2008,     0));
        vq.push_back(v(NO, 12'hC00, 32'h0,        0, 32'h0,        32'h0,        0, 32'h5,        0, 32'h2008,     0));
        vq.push_back(v(RS, 12'hF12, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00180006, 0, 32'h2008,     0));
        vq.push_back(v(RS, 12'h7C0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h2008,     0));
        vq.push_back(v(RS, 12'hF11, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h2008,     0));
        vq.push_back(v(RC, 12'hF11, 32'h1,        0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h2008,     0));
        vq.push_back(v(RW, 12'h300, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        0, 32'h1880,     0, 32'h2008,     0));
        vq.push_back(v(NO, 12'h300, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1888,     0, 32'h2008,     1));
        vq.push_back(v(RW, 12'h341, 32'h1237,     0, 32'h0,        32'h0,        0, 32'h2008,     0, 32'h2008,     1));
        vq.push_back(v(NO, 12'h341, 32'h0,        0, 32'h0,        32'h0,        0, 32'h1234,     0, 32'h1234,     1));
        vq.push_back(v(RW, 12'h340, 32'h999,      0, 32'h0,        32'h0,        1, 32'h0000BEFF, 0, 32'h1234,     1));
        vq.push_back(v(NO, 12'h340, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000BEFF, 0, 32'h1234,     1));

        reset = 1'b1;
        drive(NO, 12'h300, 0, 0, 0, 0, 0);
        #12;
        chk("reset_mtvec", mtvec, 32'h0);
        chk("reset_mepc", mepc, 32'h0);
        chk("reset_mie", {31'b0, mie_global}, 32'h0);
        chk("reset_mstatus", csr_rdata, 32'h1800);

        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();

        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].addr, vq[i].src, vq[i].tv, vq[i].cause, vq[i].pc, vq[i].mr);
            @(negedge clk);
            chk($sformatf("row%0d_rdata", i), csr_rdata, vq[i].rd);
            chk($sformatf("row%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vq[i].ill});
            chk($sformatf("row%0d_mepc", i), mepc, vq[i].ep);
            chk($sformatf("row%0d_mie", i), {31'b0, mie_global}, {31'b0, vq[i].mie});
            tick();
        end

        // Reset asserted with live state must clear it without waiting for a clock.
        drive(NO, 12'h300, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("midreset_mtvec", mtvec, 32'h0);
        chk("midreset_mepc", mepc, 32'h0);
        chk("midreset_mie", {31'b0, mie_global}, 32'h0);
        chk("midreset_mstatus", csr_rdata, 32'h1800);
        csr_addr = 12'hB00;
        #1;
        chk("midreset_mcycle", csr_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        chk("postreset_mcycle", csr_rdata, 32'h0);
        tick();
        @(negedge clk);
        chk("postreset_mcycle_inc", csr_rdata, 32'h1);
        tick();

        for (int n = 0; n < 400; n++) begin
            int k;
            logic [11:0] a;
            logic [31:0] s;
            k = $urandom_range(0, 12);
            a = (k == 12) ? 12'($urandom()) : addrs[k];
            s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            drive(2'($urandom_range(0, 3)), a, s, ($urandom_range(0, 7) == 0),
                  $urandom(), $urandom(), ($urandom_range(0, 7) == 0));
            @(negedge clk);
            m_expect(e_rd, e_ill, e_wr, e_nv);
            chk($sformatf("rnd%0d_rdata@%03h", n, a), csr_rdata, e_rd);
            chk($sformatf("rnd%0d_illegal", n), {31'b0, csr_illegal}, {31'b0, e_ill});
            chk($sformatf("rnd%0d_mtvec", n), mtvec, m_mtvec);
            chk($sformatf("rnd%0d_mepc", n), mepc, m_mepc);
            chk($sformatf("rnd%0d_mie", n), {31'b0, mie_global}, {31'b0, m_mie});
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
